dmem_lane_ctrl: RTL and testbench
=================================

// Module: dmem_lane_ctrl
// PURPOSE
//   Parametrised byte-lane data memory for the MIPS datapath. Serves one load/store per
//   cycle through a valid/ready request port and returns a fixed-latency response.
//   Adds the following to the previous data memory:
//   - read-modify-write byte/half stores that preserve the untouched lanes
//   - signed or unsigned load extension
//   - alignment and range error reporting
//   - a hardware zero-fill sequencer
// PARAMETERS
//   DATA_W   32    word width in bits; must be a multiple of 8 (NB = DATA_W/8 lanes)
//   DEPTH    1024  number of words
//   ADDR_W   12    byte-address width; word index = req_addr[ADDR_W-1:2]
//   RD_LAT   1     request-to-response latency in cycles; legal values are 1 and 2
// PORTS
//   clk        in   1       clock, all state updates on posedge
//   rst_n      in   1       asynchronous, active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       request accepted when req_valid & req_ready
//   req_we     in   1       1 = store, 0 = load
//   req_addr   in   ADDR_W  byte address, little-endian lanes
//   req_size   in   2       00 = word, 01 = byte, 10 = half, 11 = illegal
//   req_signed in   1       loads: 1 = sign-extend, 0 = zero-extend
//   req_wdata  in   DATA_W  store data, right-justified (byte in [7:0], half in [15:0])
//   rsp_valid  out  1       one-cycle pulse, exactly one per accepted request
//   rsp_rdata  out  DATA_W  load result; 0 for stores and for errors
//   rsp_err    out  1       misaligned, out-of-range or illegal-size request
//   clr_start  in   1       pulse: zero-fill the whole array
//   clr_busy   out  1       high while zero-fill runs
// BEHAVIOUR
//   Reset (rst_n low, asynchronous)
//   - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clr_busy=0.
//   - FSM goes to IDLE; the fill counter goes to 0.
//   - All in-flight responses are discarded.
//   - Array contents are not touched by reset.
//   FSM
//   - IDLE -> CLEAR when clr_start=1.
//   - CLEAR walks index 0..DEPTH-1, writing 0 to one word per cycle.
//   - After index DEPTH-1 is written, CLEAR -> IDLE. Total: exactly DEPTH cycles with clr_busy=1.
//   - clr_start is ignored while in CLEAR.
//   Handshake
//   - req_ready = (state==IDLE) & ~clr_start. A clear requested in the same cycle wins.
//   - Responses cannot be back-pressured.
//   - Responses still in flight when CLEAR begins are delivered normally during CLEAR.
//   Error checks
//   - Error when size=word and addr[1:0]!=0.
//   - Error when size=half and addr[0]=1.
//   - Error when size=11.
//   - Error when word index >= DEPTH.
//   - On error: no array write, rsp_err=1, rsp_rdata=0.
//   Stores
//   - Commit at the accepting clock edge.
//   - Byte: writes lane addr[1:0]. Half: writes lanes {addr[1],0} and {addr[1],1}.
//   - Word: writes all lanes. All other lanes keep their old value.
//   - rsp_valid is pulsed with rsp_rdata=0 and rsp_err=0.
//   Loads
//   - Lane selection is the same as for stores.
//   - The result is extended to DATA_W by req_signed (sign bit = bit 7 or bit 15 of the selected data).
//   - Word loads ignore req_signed.
//   Latency
//   - rsp_valid asserts exactly RD_LAT cycles after the accept edge.
//   - RD_LAT=2 adds an output register stage.
//   - Back-to-back accepts give back-to-back responses, in order.
//   Hazards
//   - A load accepted the cycle after a store to the same word returns the new data.
//   Reset during CLEAR
//   - The fill aborts and the array stays partially zeroed.
//   - After reset the block returns to IDLE with req_ready=1.
// TESTING
//   1. Store word 0xDEADBEEF @0x010, then load byte @0x013 signed -> rsp_rdata=0xFFFFFFDE.
//      The same load unsigned -> 0x000000DE. Load half @0x012 signed -> 0xFFFFDEAD.
//   2. Word 0x11223344 @0x020, then store byte 0xAA @0x021 -> word load @0x020 = 0x1122AA44 (lanes preserved).
//   3. Loads: half @0x003, word @0x002, size=11 -> each gives rsp_err=1, rsp_rdata=0. Stores of the same:
//      rsp_err=1 and the array is unchanged.
//   4. RD_LAT=1 and RD_LAT=2: 8 back-to-back loads -> 8 consecutive rsp_valid pulses, in order,
//      first one RD_LAT cycles after the first accept.
//   5. Fill non-zero data, pulse clr_start -> clr_busy high for exactly DEPTH cycles and req_ready=0 throughout;
//      afterwards every word loads 0.
//   6. Drop rst_n mid-CLEAR at index 100 -> clr_busy=0 immediately; words 0..99 = 0, word 100+ unchanged.
//      rsp_valid stays 0 for the pending load.

Source files
------------

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane data memory: one load/store per cycle, RD_LAT-cycle response, RMW sub-word stores, zero-fill sequencer.
// Latency RD_LAT (1 or 2); requests are held off (req_ready=0) while the zero-fill runs, responses never stall.
module dmem_lane_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              clr_start,
    output logic              clr_busy
);
    localparam int NB     = DATA_W / 8;
    localparam int IDX_W  = ADDR_W - 2;
    localparam int FILL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0]  DEPTH_L  = (IDX_W + 1)'(DEPTH);
    localparam logic [FILL_W-1:0] LAST_IX = FILL_W'(DEPTH - 1);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [IDX_W-1:0]  idx;
    logic [FILL_W-1:0] midx;
    logic [1:0]        lane;
    logic              err, accept;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] rd_word, wr_word, ld_ext;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              v1_q;
    logic              e1_q;
    logic [DATA_W-1:0] d1_q, d1_d;

    assign idx  = req_addr[ADDR_W-1:2];
    assign midx = idx[FILL_W-1:0];
    assign lane = req_addr[1:0];

    assign err = (req_size == 2'b11)
               | ((req_size == SZ_WORD) & (lane != 2'b00))
               | ((req_size == SZ_HALF) & lane[0])
               | ({1'b0, idx} >= DEPTH_L);

    // A clear pulse in the same cycle as a request wins; ready is also forced low in reset.
    assign req_ready = rst_n & (state_q == S_IDLE) & ~clr_start;
    assign accept    = req_valid & req_ready;
    assign clr_busy  = (state_q == S_CLEAR);

    // Asynchronous read so a load right after a store to the same word sees the committed data.
    assign rd_word = mem[midx];
    assign ld_byte = rd_word[{lane, 3'b000} +: 8];
    assign ld_half = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        be = '0;
        unique case (req_size)
            SZ_WORD: be = '1;
            SZ_BYTE: be[lane] = 1'b1;
            SZ_HALF: begin
                be[{lane[1], 1'b0}] = 1'b1;
                be[{lane[1], 1'b1}] = 1'b1;
            end
            default: be = '0;
        endcase
    end

    always_comb begin
        wr_word = rd_word;
        for (int l = 0; l < NB; l++) begin
            if (be[l]) begin
                unique case (req_size)
                    SZ_BYTE: wr_word[8*l +: 8] = req_wdata[7:0];
                    SZ_HALF: wr_word[8*l +: 8] = req_wdata[8*(l%2) +: 8];
                    default: wr_word[8*l +: 8] = req_wdata[8*l +: 8];
                endcase
            end
        end
    end

    always_comb begin
        ld_ext = rd_word;
        unique case (req_size)
            SZ_BYTE: ld_ext = req_signed ? {{(DATA_W-8){ld_byte[7]}}, ld_byte}
                                         : {{(DATA_W-8){1'b0}}, ld_byte};
            SZ_HALF: ld_ext = req_signed ? {{(DATA_W-16){ld_half[15]}}, ld_half}
                                         : {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_ext = rd_word;
        endcase
    end

    assign d1_d = (req_we | err) ? '0 : ld_ext;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        unique case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                    fill_d  = '0;
                end
            end
            default: begin
                fill_d = fill_q + 1'b1;
                if (fill_q == LAST_IX) begin
                    state_d = S_IDLE;
                    fill_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fill_q  <= '0;
            v1_q    <= 1'b0;
            e1_q    <= 1'b0;
            d1_q    <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            v1_q    <= accept;
            e1_q    <= accept & err;
            d1_q    <= accept ? d1_d : '0;
        end
    end

    // Array has no reset: a reset mid-fill leaves it partially zeroed.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR)
            mem[fill_q] <= '0;
        else if (accept & req_we & ~err)
            mem[midx] <= wr_word;
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              v2_q, e2_q;
            logic [DATA_W-1:0] d2_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2_q <= 1'b0;
                    e2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    e2_q <= e1_q;
                    d2_q <= d1_q;
                end
            end
            assign rsp_valid = v2_q;
            assign rsp_err   = e2_q;
            assign rsp_rdata = d2_q;
        end else begin : g_lat1
            assign rsp_valid = v1_q;
            assign rsp_err   = e1_q;
            assign rsp_rdata = d1_q;
        end
    endgenerate
endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Scoreboard bench: two instances (RD_LAT=1 and RD_LAT=2) share stimulus; each response is checked for data, error and arrival cycle.
module tb_dmem_lane_ctrl;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, clr_start = 1'b0;
    logic [11:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_wdata = '0;

    logic        rdy1, rv1, re1, busy1;
    logic        rdy2, rv2, re2, busy2;
    logic [31:0] rd1, rd2;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_lane_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(12), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1), .clr_start(clr_start), .clr_busy(busy1));

    dmem_lane_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(12), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
        .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2), .clr_start(clr_start), .clr_busy(busy2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: pops on every response, and flags a response that is overdue.
    always @(negedge clk) begin
        exp_t e;
        if (rv1) begin
            if (q1.size() == 0) fail_now("lat1 unexpected rsp_valid");
            else begin
                e = q1.pop_front();
                chk("lat1 rdata", rd1, e.d);
                chk("lat1 err", {31'b0, re1}, {31'b0, e.e});
                chk("lat1 arrival cycle", 32'(cyc), 32'(e.due));
            end
        end else if (q1.size() != 0 && q1[0].due <= cyc) begin
            fail_now("lat1 missing response");
            void'(q1.pop_front());
        end
        if (rv2) begin
            if (q2.size() == 0) fail_now("lat2 unexpected rsp_valid");
            else begin
                e = q2.pop_front();
                chk("lat2 rdata", rd2, e.d);
                chk("lat2 err", {31'b0, re2}, {31'b0, e.e});
                chk("lat2 arrival cycle", 32'(cyc), 32'(e.due));
            end
        end else if (q2.size() != 0 && q2[0].due <= cyc) begin
            fail_now("lat2 missing response");
            void'(q2.pop_front());
        end
    end

    // Called at a negedge; the request is accepted at the following posedge.
    task automatic issue(input logic we, input logic [11:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wd;
        #1;
        if (rdy1 !== 1'b1 || rdy2 !== 1'b1) fail_now("req_ready low on issue");
        e.d = exp_d; e.e = exp_e;
        e.due = cyc + 1; q1.push_back(e);
        e.due = cyc + 2; q2.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic st(input logic [11:0] a, input logic [1:0] s, input logic [31:0] wd, input logic e);
        issue(1'b1, a, s, 1'b0, wd, 32'h0, e);
    endtask

    task automatic ld(input logic [11:0] a, input logic [1:0] s, input logic sgn,
                      input logic [31:0] d, input logic e);
        issue(1'b0, a, s, sgn, 32'h0, d, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int rdy_bad;
        #3;
        chk("reset req_ready", {30'b0, rdy1, rdy2}, 32'h0);
        chk("reset rsp_valid", {30'b0, rv1, rv2}, 32'h0);
        chk("reset rsp_err", {30'b0, re1, re2}, 32'h0);
        chk("reset clr_busy", {30'b0, busy1, busy2}, 32'h0);
        chk("reset rdata lat1", rd1, 32'h0);
        chk("reset rdata lat2", rd2, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset req_ready", {30'b0, rdy1, rdy2}, 32'h3);
        @(negedge clk);

        // Sign/zero extension of sub-word loads
        st(12'h010, 2'b00, 32'hDEADBEEF, 1'b0);
        ld(12'h013, 2'b01, 1'b1, 32'hFFFFFFDE, 1'b0);
        ld(12'h013, 2'b01, 1'b0, 32'h000000DE, 1'b0);
        ld(12'h012, 2'b10, 1'b1, 32'hFFFFDEAD, 1'b0);
        ld(12'h010, 2'b10, 1'b0, 32'h0000BEEF, 1'b0);
        ld(12'h010, 2'b00, 1'b1, 32'hDEADBEEF, 1'b0);

        // Lane-preserving sub-word stores; the load right after a store sees new data
        st(12'h020, 2'b00, 32'h11223344, 1'b0);
        st(12'h021, 2'b01, 32'h000000AA, 1'b0);
        ld(12'h020, 2'b00, 1'b0, 32'h1122AA44, 1'b0);
        st(12'h022, 2'b10, 32'h00005566, 1'b0);
        ld(12'h020, 2'b00, 1'b0, 32'h5566AA44, 1'b0);
        ld(12'h020, 2'b10, 1'b1, 32'hFFFFAA44, 1'b0);
        ld(12'h020, 2'b01, 1'b1, 32'h00000044, 1'b0);

        // Errors: misaligned, illegal size, out of range; array must stay untouched
        st(12'h000, 2'b00, 32'h0BADF00D, 1'b0);
        ld(12'h003, 2'b10, 1'b0, 32'h0, 1'b1);
        ld(12'h002, 2'b00, 1'b0, 32'h0, 1'b1);
        ld(12'h000, 2'b11, 1'b0, 32'h0, 1'b1);
        ld(12'h400, 2'b00, 1'b0, 32'h0, 1'b1);
        st(12'h003, 2'b10, 32'hFFFFFFFF, 1'b1);
        st(12'h002, 2'b00, 32'hFFFFFFFF, 1'b1);
        st(12'h000, 2'b11, 32'hFFFFFFFF, 1'b1);
        st(12'h400, 2'b00, 32'hFFFFFFFF, 1'b1);
        ld(12'h000, 2'b00, 1'b0, 32'h0BADF00D, 1'b0);

        // Eight back-to-back loads
        for (int i = 0; i < 8; i++) st(12'(12'h040 + 4*i), 2'b00, 32'hA0000000 | i, 1'b0);
        for (int i = 0; i < 8; i++) ld(12'(12'h040 + 4*i), 2'b00, 1'b0, 32'hA0000000 | i, 1'b0);

        // Zero-fill with a load still in flight; a simultaneous request loses to the clear
        ld(12'h010, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0);
        clr_start = 1'b1; req_valid = 1'b1; req_addr = 12'h020; req_size = 2'b00; req_we = 1'b0;
        #1;
        chk("req_ready with clr_start", {30'b0, rdy1, rdy2}, 32'h0);
        @(negedge clk);
        clr_start = 1'b0; req_valid = 1'b0;
        cnt = 0; rdy_bad = 0;
        while (busy1 === 1'b1 && cnt < DEPTH + 10) begin
            if (rdy1 !== 1'b0 || rdy2 !== 1'b0 || busy2 !== 1'b1) rdy_bad++;
            cnt++;
            @(negedge clk);
        end
        chk("clr_busy cycles", 32'(cnt), 32'(DEPTH));
        chk("ready/busy during clear", 32'(rdy_bad), 32'h0);
        chk("busy after clear", {30'b0, busy1, busy2}, 32'h0);
        for (int i = 0; i < DEPTH; i++) ld(12'(4*i), 2'b00, 1'b0, 32'h0, 1'b0);

        // Reset at fill index 100
        for (int i = 98; i < 102; i++) st(12'(4*i), 2'b00, 32'h1000 + i, 1'b0);
        repeat (3) @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("busy on reset mid-clear", {30'b0, busy1, busy2}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after mid-clear reset", {30'b0, rdy1, rdy2}, 32'h3);
        ld(12'(4*98), 2'b00, 1'b0, 32'h0, 1'b0);
        ld(12'(4*99), 2'b00, 1'b0, 32'h0, 1'b0);
        ld(12'(4*100), 2'b00, 1'b0, 32'h1000 + 100, 1'b0);
        ld(12'(4*101), 2'b00, 1'b0, 32'h1000 + 101, 1'b0);

        repeat (5) @(negedge clk);
        if (q1.size() != 0 || q2.size() != 0) fail_now("responses left undelivered");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
